// File: rtl/flop_defs.sv
// Shared definitions for the flip-flop block family.
// - state_e   : serializer FSM encodings (IDLE/SHIFT/GAP)
// - GAP_CNT_W : width of the post-frame gap counter (covers 0..15)
// - cnt_w()   : bit-counter width for a given word width
package flop_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int GAP_CNT_W = 4;

  // One extra bit over clog2 so the counter can hold WIDTH itself,
  // which marks the frame-end cycle.
  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/dff_ar_n.sv
// Single D flip-flop with asynchronous active-low reset.
// Ports:
//   clk   in  : rising-edge clock
//   rst_n in  : async active-low reset, forces q to RST_VAL
//   d     in  : data
//   q     out : registered data
//   qbar  out : ~q at all times, including during reset
module dff_ar_n #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic qbar
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_VAL;
    else        q <= d;
  end

  assign qbar = ~q;

endmodule

// File: rtl/dff_serializer.sv
// Parallel-in, serial-out transmitter (driving end of the D/Q interface).
// A WIDTH-bit word is accepted on load_valid && load_ready and shifted out
// one bit per clock, followed by a one-cycle done pulse and an optional gap.
// Ports:
//   clk, rst_n  : rising-edge clock, async active-low reset
//   din         : parallel word, sampled only on handshake
//   load_valid  : din is valid
//   load_ready  : state decode, high in IDLE
//   sout/sout_n : registered serial bit and its complement
//   sframe      : registered, high while sout carries a payload bit
//   busy        : state decode, high in SHIFT or GAP
//   done        : registered one-cycle pulse at frame end
module dff_serializer
  import flop_defs::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_n,
  output logic             sframe,
  output logic             busy,
  output logic             done
);

  localparam int                    CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0]         CNT_LAST = CW'(WIDTH);
  localparam logic [GAP_CNT_W-1:0]  GAP_LAST =
    (GAP_CYCLES > 0) ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     shreg_q, shreg_d, shifted;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [GAP_CNT_W-1:0] gap_q, gap_d;
  logic                 sframe_q, sframe_d;
  logic                 done_q, done_d;
  logic                 sout_d;

  // The register always holds the word with the next bit to send at the
  // "first" end, so sout is just that end of the next-state value.
  assign shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                             : {1'b0, shreg_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    sout_d   = 1'b0;
    sframe_d = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          shreg_d  = din;
          sout_d   = MSB_FIRST ? din[WIDTH-1] : din[0];
          sframe_d = 1'b1;
          cnt_d    = CW'(1);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          // Frame end: payload gone, pulse done, counters wrap.
          shreg_d = '0;
          cnt_d   = '0;
          gap_d   = '0;
          done_d  = 1'b1;
          state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
        end else begin
          shreg_d  = shifted;
          sout_d   = MSB_FIRST ? shifted[WIDTH-1] : shifted[0];
          sframe_d = 1'b1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      sframe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      sframe_q <= sframe_d;
      done_q   <= done_d;
    end
  end

  dff_ar_n #(.RST_VAL(1'b0)) u_sout (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sout_d),
    .q    (sout),
    .qbar (sout_n)
  );

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign sframe     = sframe_q;
  assign done       = done_q;

endmodule

// File: tb/tb_dff_serializer.sv
// Bench for dff_serializer: three instances cover MSB-first/no gap (0),
// LSB-first/no gap (1) and MSB-first/gap=2 (2).
module tb_dff_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] lv = '0;
  logic [7:0] din [3];
  logic [2:0] lr, so, sn, sf, bz, dn;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dff_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .din(din[0]), .load_valid(lv[0]),
    .load_ready(lr[0]), .sout(so[0]), .sout_n(sn[0]), .sframe(sf[0]),
    .busy(bz[0]), .done(dn[0]));

  dff_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .din(din[1]), .load_valid(lv[1]),
    .load_ready(lr[1]), .sout(so[1]), .sout_n(sn[1]), .sframe(sf[1]),
    .busy(bz[1]), .done(dn[1]));

  dff_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .din(din[2]), .load_valid(lv[2]),
    .load_ready(lr[2]), .sout(so[2]), .sout_n(sn[2]), .sframe(sf[2]),
    .busy(bz[2]), .done(dn[2]));

  // bits[7] is the first bit expected on sout, bits[0] the last.
  typedef struct {
    int         dut;
    logic [7:0] w;
    logic [7:0] bits;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int d);
    int n = 0;
    while (!lr[d] && n < 50) begin
      step();
      n++;
    end
    chk("ready_timeout", {31'd0, lr[d]}, 32'd1);
  endtask

  task automatic chk_reset_vals(input int d);
    chk("rst_sout",   {31'd0, so[d]}, 32'd0);
    chk("rst_sout_n", {31'd0, sn[d]}, 32'd1);
    chk("rst_sframe", {31'd0, sf[d]}, 32'd0);
    chk("rst_busy",   {31'd0, bz[d]}, 32'd0);
    chk("rst_done",   {31'd0, dn[d]}, 32'd0);
    chk("rst_ready",  {31'd0, lr[d]}, 32'd1);
  endtask

  task automatic send(input int d, input logic [7:0] w, input logic [7:0] bits);
    wait_ready(d);
    din[d] = w;
    lv[d]  = 1'b1;
    step();                         // acceptance edge
    lv[d]  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("bit_sout",   {31'd0, so[d]}, {31'd0, bits[7-i]});
      chk("bit_sout_n", {31'd0, sn[d]}, {31'd0, ~bits[7-i]});
      chk("bit_sframe", {31'd0, sf[d]}, 32'd1);
      chk("bit_busy",   {31'd0, bz[d]}, 32'd1);
      chk("bit_ready",  {31'd0, lr[d]}, 32'd0);
      chk("bit_done",   {31'd0, dn[d]}, 32'd0);
      if (i < 7) step();
    end
    step();
    chk("end_done",   {31'd0, dn[d]}, 32'd1);
    chk("end_sframe", {31'd0, sf[d]}, 32'd0);
    chk("end_sout",   {31'd0, so[d]}, 32'd0);
    chk("end_sout_n", {31'd0, sn[d]}, 32'd1);
    step();
    chk("post_done",  {31'd0, dn[d]}, 32'd0);
  endtask

  initial begin
    logic [7:0] got;
    int n;
    int first_dn, second_dn;
    logic exp_sf, exp_dn;

    for (int i = 0; i < 3; i++) din[i] = '0;

    vecs[0] = '{dut: 0, w: 8'hA5, bits: 8'hA5};
    vecs[1] = '{dut: 0, w: 8'h3C, bits: 8'h3C};
    vecs[2] = '{dut: 1, w: 8'h01, bits: 8'h80};  // LSB first: 1,0,0,0,0,0,0,0
    vecs[3] = '{dut: 1, w: 8'h0E, bits: 8'h70};  // LSB first: 0,1,1,1,0,0,0,0
    vecs[4] = '{dut: 2, w: 8'hC3, bits: 8'hC3};

    // Reset asserted away from any clock edge; outputs must settle at once.
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) chk_reset_vals(d);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();

    for (int v = 0; v < 5; v++) send(vecs[v].dut, vecs[v].w, vecs[v].bits);

    // Gap instance: second word held on the bus must wait 11 cycles.
    wait_ready(2);
    din[2] = 8'hC3;
    lv[2]  = 1'b1;
    step();                         // edge k
    din[2] = 8'h3C;
    got = '0;
    got[7] = so[2];
    n = 0;
    while (!lr[2] && n < 30) begin
      step();
      n++;
      if (n < 8) got[7-n] = so[2];
    end
    chk("gap_first_frame", {24'd0, got}, 32'h0000_00C3);
    chk("gap_accept_spacing", n + 1, 11);
    step();                         // second acceptance edge
    lv[2] = 1'b0;
    got = '0;
    for (int i = 0; i < 8; i++) begin
      got[7-i] = so[2];
      chk("gap_2nd_sframe", {31'd0, sf[2]}, 32'd1);
      if (i < 7) step();
    end
    chk("gap_second_frame", {24'd0, got}, 32'h0000_003C);
    step();
    chk("gap_2nd_done", {31'd0, dn[2]}, 32'd1);
    step();
    chk("gap_busy_in_gap", {31'd0, bz[2]}, 32'd1);
    chk("gap_ready_in_gap", {31'd0, lr[2]}, 32'd0);

    // Mid-frame reset: abort during bit 4 without a clock edge.
    wait_ready(0);
    din[0] = 8'hFF;
    lv[0]  = 1'b1;
    step();
    lv[0]  = 1'b0;
    repeat (4) step();              // now presenting bit 4
    chk("abort_bit4", {31'd0, so[0]}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals(0);
    @(posedge clk);
    #1;
    chk("abort_done_in_rst", {31'd0, dn[0]}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("abort_no_done", {31'd0, dn[0]}, 32'd0);
    chk("abort_ready",   {31'd0, lr[0]}, 32'd1);
    send(0, 8'h81, 8'h81);

    // Back-to-back FF then 00 with load_valid held.
    wait_ready(0);
    din[0] = 8'hFF;
    lv[0]  = 1'b1;
    step();                         // edge k, c = 0
    din[0] = 8'h00;
    first_dn  = -1;
    second_dn = -1;
    for (int c = 0; c < 19; c++) begin
      exp_sf = (c <= 7) || (c >= 9 && c <= 16);
      exp_dn = (c == 8) || (c == 17);
      chk("b2b_sframe", {31'd0, sf[0]}, {31'd0, exp_sf});
      chk("b2b_done",   {31'd0, dn[0]}, {31'd0, exp_dn});
      if (c <= 7)               chk("b2b_sout_ff", {31'd0, so[0]}, 32'd1);
      if (c >= 9 && c <= 16)    chk("b2b_sout_00", {31'd0, so[0]}, 32'd0);
      if (dn[0] && first_dn < 0)       first_dn = c;
      else if (dn[0] && second_dn < 0) second_dn = c;
      if (c == 9) lv[0] = 1'b0;
      step();
    end
    chk("b2b_done_spacing", second_dn - first_dn, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
